// File: rtl/aes_blk_serial_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | aes_blk_serial_arbiter: round-robin grant of 128-bit blocks, sent as 4x32b |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module aes_blk_serial_arbiter #(
  parameter int N_REQ     = 2,
  parameter int MSW_FIRST = 0,
  parameter int CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*128-1:0]   req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   out_valid,
  output logic [31:0]            out_data,
  output logic                   out_last,
  output logic [1:0]             out_src,
  input  logic                   out_ready,
  output logic                   busy,
  output logic [CNT_W-1:0]       blocks_done
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t       state_q;
  logic [1:0]   rr_ptr_q;
  logic [1:0]   beat_q;
  logic [127:0] hold_q;

  logic [3:0]   valid_pad;
  logic [1:0]   grant_d;
  logic         any_d;
  logic [127:0] sel_blk_d;
  logic [1:0]   rr_next_d;

  function automatic logic [1:0] wrap_idx(input logic [1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return s[1:0];
  endfunction

  // For MSW-first order, chunk k lives at word 3-k, which is ~k in two bits.
  function automatic logic [31:0] chunk(input logic [127:0] blk, input logic [1:0] k);
    logic [1:0] sel;
    sel = (MSW_FIRST != 0) ? ~k : k;
    return blk[{sel, 5'b0} +: 32];
  endfunction

  assign valid_pad = 4'(req_valid);

  // Scan from the highest offset down so the offset nearest rr_ptr wins.
  always_comb begin
    grant_d = 2'd0;
    any_d   = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (valid_pad[wrap_idx(rr_ptr_q, k)]) begin
        grant_d = wrap_idx(rr_ptr_q, k);
        any_d   = 1'b1;
      end
    end
  end

  always_comb begin
    sel_blk_d = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_d == 2'(i)) sel_blk_d = req_data[i*128 +: 128];
    end
  end

  assign rr_next_d = (grant_d == 2'(N_REQ - 1)) ? 2'd0 : grant_d + 2'd1;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = (state_q == S_IDLE) && any_d && (grant_d == 2'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= 2'd0;
      beat_q      <= 2'd0;
      hold_q      <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_last    <= 1'b0;
      out_src     <= 2'd0;
      busy        <= 1'b0;
      blocks_done <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (any_d) begin
            hold_q    <= sel_blk_d;
            out_src   <= grant_d;
            beat_q    <= 2'd0;
            rr_ptr_q  <= rr_next_d;
            out_valid <= 1'b1;
            busy      <= 1'b1;
            out_last  <= 1'b0;
            out_data  <= chunk(sel_blk_d, 2'd0);
            state_q   <= S_SEND;
          end
        end
        S_SEND: begin
          if (out_ready) begin
            if (beat_q == 2'd3) begin
              state_q     <= S_IDLE;
              out_valid   <= 1'b0;
              out_last    <= 1'b0;
              busy        <= 1'b0;
              blocks_done <= blocks_done + CNT_W'(1);
            end else begin
              beat_q   <= beat_q + 2'd1;
              out_data <= chunk(hold_q, beat_q + 2'd1);
              out_last <= (beat_q == 2'd2);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
